// File: rtl/bitstream_bit_server.sv
// Bitstream bit server: buffers 32-bit big-endian stream words in a 64-bit
// left-aligned shift buffer and serves them as single bits, fixed-length
// fields (up to MAX_FIELD bits) and byte-alignment skips.
module bitstream_bit_server #(
   parameter int MAX_FIELD = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          Word_Data_I,
   input  logic                 Word_Valid_I,
   output logic                 Word_Ready_O,
   output logic                 Bit_O,
   output logic                 Bit_Valid_O,
   input  logic                 Shift_En_I,
   input  logic                 Field_Req_I,
   input  logic [4:0]           Field_Len_I,
   output logic [MAX_FIELD-1:0] Field_O,
   output logic                 Field_Valid_O,
   input  logic                 Align_Req_I,
   output logic                 Align_Done_O,
   output logic [31:0]          Bits_Consumed_O
);

   // Buffer state: valid bits sit at the top, everything below fill is zero.
   logic [63:0]          r_buffer;
   logic [6:0]           r_fill;
   logic [31:0]          r_consumed;
   logic [MAX_FIELD-1:0] r_field;
   logic                 r_field_valid;
   logic                 r_align_done;

   logic [4:0]           w_len;
   logic [2:0]           w_align_n;
   logic [5:0]           w_field_shamt;
   logic [MAX_FIELD-1:0] w_field_val;
   logic                 w_word_ready;
   logic                 w_accept;
   logic                 w_field_go;
   logic                 w_align_go;
   logic [4:0]           w_consume;
   logic [6:0]           w_fill_after;
   logic [63:0]          w_shifted;
   logic [63:0]          w_placed;
   logic [63:0]          w_buffer_next;
   logic [6:0]           w_fill_next;

   // Field length clamp, alignment distance and right-aligned field value.
   assign w_len         = (Field_Len_I > 5'(MAX_FIELD)) ? 5'(MAX_FIELD) : Field_Len_I;
   assign w_align_n     = 3'd0 - r_consumed[2:0];
   assign w_field_shamt = 6'(MAX_FIELD) - {1'b0, w_len};
   // A zero-length field shifts the whole window out, yielding 0.
   assign w_field_val   = r_buffer[63 -: MAX_FIELD] >> w_field_shamt;

   // Space for a whole word exists only when at most 32 bits are held.
   assign w_word_ready  = (r_fill <= 7'd32);
   assign w_accept      = Word_Valid_I & w_word_ready;

   // Pick one consumer per cycle (align > field > shift) and its bit count.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_align_go = 1'b0;
      w_field_go = 1'b0;
      w_consume  = 5'd0;
      if (Align_Req_I) begin
         if (r_fill >= {4'd0, w_align_n}) begin
            w_align_go = 1'b1;
            w_consume  = {2'd0, w_align_n};
         end
      end else if (Field_Req_I) begin
         if (r_fill >= {2'd0, w_len}) begin
            w_field_go = 1'b1;
            w_consume  = w_len;
         end
      end else if (Shift_En_I) begin
         if (r_fill != 7'd0) begin
            w_consume = 5'd1;
         end
      end
   end

   // Drop consumed bits, then append an accepted word just below the survivors.
   assign w_fill_after  = r_fill - {2'd0, w_consume};
   assign w_shifted     = r_buffer << w_consume;
   assign w_placed      = {Word_Data_I, 32'd0} >> w_fill_after;
   assign w_buffer_next = w_accept ? (w_shifted | w_placed) : w_shifted;
   assign w_fill_next   = w_accept ? (w_fill_after + 7'd32) : w_fill_after;

   // State register: buffer, fill, consumed count and the result pulses.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples this cycle's values regardless of statement order.
      if (reset) begin
         r_buffer      <= '0;
         r_fill        <= '0;
         r_consumed    <= '0;
         r_field       <= '0;
         r_field_valid <= 1'b0;
         r_align_done  <= 1'b0;
      end else begin
         r_buffer      <= w_buffer_next;
         r_fill        <= w_fill_next;
         r_consumed    <= r_consumed + {27'd0, w_consume};
         r_field_valid <= w_field_go;
         r_align_done  <= w_align_go;
         if (w_field_go) begin
            r_field <= w_field_val;
         end
      end
   end

   // Status outputs follow registered fill and are held low during reset.
   assign Word_Ready_O    = ~reset & w_word_ready;
   assign Bit_Valid_O     = ~reset & (r_fill != 7'd0);
   assign Bit_O           = ~reset & (r_fill != 7'd0) & r_buffer[63];
   assign Field_O         = r_field;
   assign Field_Valid_O   = r_field_valid;
   assign Align_Done_O    = r_align_done;
   assign Bits_Consumed_O = r_consumed;

endmodule

// File: doc/bitstream_bit_server.md
Name: bitstream_bit_server

Overview:
- Upstream feeder for the bit-serial VLC decoders in the slice path, such as the macroblock_type, motion code and coefficient table walkers.
- Accepts 32-bit big-endian bitstream words from the input FIFO and holds them in a 64-bit left-aligned buffer.
- Presents the current MSB as a serial bit and consumes one bit per shift enable.
- Also serves fixed-length field reads (for example quantiser_scale_code and f_code) and byte-alignment requests for start-code search.

Parameters:
- MAX_FIELD, 16, maximum fixed-length field width in bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Word_Data_I  in  32  next bitstream word; bit 31 is first in stream order.
- Word_Valid_I  in  1  Word_Data_I is valid.
- Word_Ready_O  out  1  block can accept a word this cycle.
- Bit_O  out  1  current stream bit (buffer MSB); drives the table walker's Data_In_I.
- Bit_Valid_O  out  1  at least one bit is buffered.
- Shift_En_I  in  1  consume one bit; driven by the walker's Shift_En_O.
- Field_Req_I  in  1  request a fixed-length field read.
- Field_Len_I  in  5  field length, 0..16.
- Field_O  out  16  field value, right-aligned and zero-extended.
- Field_Valid_O  out  1  one-cycle pulse; Field_O is valid.
- Align_Req_I  in  1  discard bits up to the next byte boundary.
- Align_Done_O  out  1  one-cycle pulse; alignment completed.
- Bits_Consumed_O  out  32  running count of consumed bits; wraps modulo 2^32.

Behaviour:
- State:
  - 64-bit buffer, left-aligned.
  - Fill count, 0..64.
  - Consumed-bit counter.
  - Field_O / Field_Valid_O / Align_Done_O output registers.
- Reset: buffer=0, fill=0, Bits_Consumed_O=0, Field_O=0, Field_Valid_O=0, Align_Done_O=0.
  - Combinational outputs are forced to 0 while reset=1 (Word_Ready_O=0, Bit_Valid_O=0, Bit_O=0).
  - Reset mid-operation discards all buffered bits and any pending request.
- Word_Ready_O = (fill <= 32), from registered fill, not gated by this cycle's consumption.
  - A word is accepted when Word_Valid_I & Word_Ready_O.
- Bit_Valid_O = (fill != 0). Bit_O = buffer[63] when fill != 0, else 0.
- Consumption: at most one source per cycle. Priority: Align_Req_I, then Field_Req_I, then Shift_En_I.
  - Shift: consumes 1 bit if fill >= 1; otherwise ignored (no state change).
  - Field:
    - Field_Len_I > 16 is clamped to 16.
    - Len L is accepted only if fill >= L; otherwise the request is ignored and the requester holds it.
    - On acceptance, Field_O <= buffer[63 -: L] right-aligned, and Field_Valid_O pulses on the next cycle (latency 1).
    - L=0: Field_O=0, pulse asserted, nothing consumed.
  - Align:
    - N = (8 - Bits_Consumed_O[2:0]) mod 8.
    - Accepted if fill >= N; consumes N bits, and Align_Done_O pulses next cycle.
    - N=0: pulse with no consumption.
    - fill < N: ignored, requester holds.
  - A lower-priority request asserted in the same cycle as an accepted higher-priority one is not serviced; its requester must hold it.
- Buffer update per cycle, with c = bits consumed this cycle:
  - buffer <= buffer << c;
  - fill' = fill - c;
  - if a word is accepted, the word is placed at bit positions [63-fill' -: 32], and fill' += 32.
  - Simultaneous accept and consume is supported in the same cycle.
  - fill never exceeds 64, because a word is accepted only when fill <= 32.
- Bits_Consumed_O += c each cycle.
- Stall cases:
  - Empty buffer with Shift_En_I: no change; the walker keeps its state because Bit_Valid_O=0 is used to gate its Start/shift.
  - Full buffer (fill=64): Word_Ready_O=0.

Test Plan:
1. Reset, then push word 0xA5000000 with no consumption -> next cycle fill=32, Bit_Valid_O=1, Bit_O=1, Word_Ready_O=1.
2. After test 1, hold Shift_En_I for 8 cycles -> Bit_O sequence 1,0,1,0,0,1,0,1, then 0; Bits_Consumed_O=8.
3. Push 0xFFFF0000 then 0x12345678; Field_Req_I with len=20 -> clamped to 16, so Field_O=0xFFFF one cycle later with a single Field_Valid_O pulse. A following len=12 read -> Field_O=0x000. A read with len=0 -> Field_O=0, pulse asserted, Bits_Consumed_O unchanged.
4. Consume 3 bits, then Align_Req_I -> 5 bits discarded, Align_Done_O pulses, Bits_Consumed_O=8. A second Align_Req_I -> immediate pulse with no consumption.
5. With fill=32, assert Word_Valid_I and Shift_En_I in the same cycle -> fill=63, and the new word's bit 31 appears exactly 31 shifts later. A further push with fill=63 -> Word_Ready_O=0 and the word is not taken.
6. Field_Req_I with len=10 while fill=4 -> no pulse while the request is held. A word arrives -> pulse on the cycle after fill >= 10. Assert reset mid-stream -> fill=0, Bit_Valid_O=0, Bits_Consumed_O=0 on the next cycle.
